// File: rtl/ttt_pkg.sv
// Shared types and width helpers for the tick-tock-tokens stage scheduler.
package ttt_pkg;

    typedef enum logic [1:0] {
        STAGE_WAIT     = 2'b00,
        STAGE_UPDATE   = 2'b01,
        STAGE_CHECK    = 2'b10,
        STAGE_TRANSMIT = 2'b11
    } stage_t;

    typedef enum logic [2:0] {
        WALK_IDLE,
        WALK_PTR0,
        WALK_PTR1,
        WALK_PTR2,
        WALK_CONN,
        WALK_DRAIN
    } walk_state_t;

    // {stop, start} codes of a processor check result
    localparam logic [1:0] SS_NONE  = 2'b00;
    localparam logic [1:0] SS_START = 2'b01;
    localparam logic [1:0] SS_STOP  = 2'b10;
    localparam logic [1:0] SS_BOTH  = 2'b11;

    function automatic int pid_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int cid_w(input int c);
        return (c > 1) ? $clog2(c) : 1;
    endfunction

    function automatic int cnt_w(input int c);
        return $clog2(c + 1);
    endfunction

endpackage

// File: rtl/ttt_csr_walker.sv
// Walks one processor's CSR fan-out list and streams weighted token deliveries.
module ttt_csr_walker
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 8,
    parameter int NUM_CONNECTIONS = 32,
    parameter int NEW_TOKEN_BITS  = 2,
    localparam int PID_W = pid_w(NUM_PROCESSORS),
    localparam int PTR_W = ptr_w(NUM_PROCESSORS),
    localparam int CID_W = cid_w(NUM_CONNECTIONS),
    localparam int CNT_W = cnt_w(NUM_CONNECTIONS)
) (
    input  logic                      clock_fast,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop_kind,
    input  logic [PID_W-1:0]          proc,
    output logic                      done,
    output logic [PTR_W-1:0]          indptr_addr,
    input  logic [CNT_W-1:0]          indptr_data,
    output logic [CID_W-1:0]          conn_addr,
    output logic                      conn_rd,
    input  logic [PID_W-1:0]          conn_target,
    input  logic [NEW_TOKEN_BITS-1:0] conn_good,
    input  logic [NEW_TOKEN_BITS-1:0] conn_bad,
    output logic                      deliver_valid,
    output logic [PID_W-1:0]          deliver_target,
    output logic [NEW_TOKEN_BITS-1:0] deliver_good,
    output logic [NEW_TOKEN_BITS-1:0] deliver_bad,
    output logic                      deliver_stop
);

    localparam logic [CNT_W-1:0] CONN_MAX = CNT_W'(NUM_CONNECTIONS);

    walk_state_t      state, state_n;
    logic [CNT_W-1:0] lo, hi, c;
    logic [CNT_W-1:0] ptr_clamped;

    assign ptr_clamped = (indptr_data > CONN_MAX) ? CONN_MAX : indptr_data;

    always_comb begin
        state_n     = state;
        done        = 1'b0;
        indptr_addr = '0;
        conn_addr   = '0;
        conn_rd     = 1'b0;
        case (state)
            WALK_IDLE:  if (start) state_n = WALK_PTR0;
            WALK_PTR0: begin
                indptr_addr = PTR_W'(proc);
                state_n     = WALK_PTR1;
            end
            WALK_PTR1: begin
                indptr_addr = PTR_W'(proc) + PTR_W'(1);
                state_n     = WALK_PTR2;
            end
            // hi arrives this cycle; an empty or inverted list ends the walk here
            WALK_PTR2: begin
                if (lo >= ptr_clamped) begin
                    done    = 1'b1;
                    state_n = WALK_IDLE;
                end else begin
                    state_n = WALK_CONN;
                end
            end
            WALK_CONN: begin
                conn_rd   = 1'b1;
                conn_addr = c[CID_W-1:0];
                if (c == hi - CNT_W'(1)) state_n = WALK_DRAIN;
            end
            WALK_DRAIN: begin
                done    = 1'b1;
                state_n = WALK_IDLE;
            end
            default:    state_n = WALK_IDLE;
        endcase
    end

    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            state         <= WALK_IDLE;
            lo            <= '0;
            hi            <= '0;
            c             <= '0;
            deliver_valid <= 1'b0;
            deliver_stop  <= 1'b0;
        end else begin
            state         <= state_n;
            deliver_valid <= conn_rd;
            if (start && state == WALK_IDLE) deliver_stop <= stop_kind;
            if (state == WALK_PTR1) lo <= ptr_clamped;
            if (state == WALK_PTR2) begin
                hi <= ptr_clamped;
                c  <= lo;
            end
            if (state == WALK_CONN) c <= c + CNT_W'(1);
        end
    end

    assign deliver_target = conn_target;
    assign deliver_good   = conn_good;
    assign deliver_bad    = conn_bad;

endmodule

// File: rtl/ttt_stage_scheduler.sv
// Per-step sequencer: sweeps update and check phases over all processors and
// hands firing processors to the CSR walker for token transmission.
module ttt_stage_scheduler
    import ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 8,
    parameter int NUM_CONNECTIONS = 32,
    parameter int NEW_TOKEN_BITS  = 2,
    localparam int PID_W = pid_w(NUM_PROCESSORS),
    localparam int PTR_W = ptr_w(NUM_PROCESSORS),
    localparam int CID_W = cid_w(NUM_CONNECTIONS),
    localparam int CNT_W = cnt_w(NUM_CONNECTIONS)
) (
    input  logic                      clock_fast,
    input  logic                      reset,
    input  logic                      advance,
    output logic [1:0]                stage,
    output logic [PID_W-1:0]          proc_addr,
    output logic                      proc_update,
    output logic                      proc_check,
    input  logic                      token_start,
    input  logic                      token_stop,
    output logic [PTR_W-1:0]          indptr_addr,
    input  logic [CNT_W-1:0]          indptr_data,
    output logic [CID_W-1:0]          conn_addr,
    output logic                      conn_rd,
    input  logic [PID_W-1:0]          conn_target,
    input  logic [NEW_TOKEN_BITS-1:0] conn_good,
    input  logic [NEW_TOKEN_BITS-1:0] conn_bad,
    output logic                      deliver_valid,
    output logic [PID_W-1:0]          deliver_target,
    output logic [NEW_TOKEN_BITS-1:0] deliver_good,
    output logic [NEW_TOKEN_BITS-1:0] deliver_bad,
    output logic                      deliver_stop,
    output logic                      out_valid,
    output logic [PID_W-1:0]          out_proc,
    output logic [1:0]                out_startstop,
    output logic                      busy
);

    localparam logic [PID_W-1:0] LAST_PROC = PID_W'(NUM_PROCESSORS - 1);

    stage_t           state, state_n;
    logic [PID_W-1:0] p, p_n;
    logic [1:0]       ss;
    logic             check_fire, walk_start, walk_done;

    assign ss         = {token_stop, token_start};
    assign check_fire = (state == STAGE_CHECK) && (ss != SS_NONE);

    always_comb begin
        state_n    = state;
        p_n        = p;
        walk_start = 1'b0;
        case (state)
            STAGE_WAIT: begin
                if (advance) begin
                    state_n = STAGE_UPDATE;
                    p_n     = '0;
                end
            end
            STAGE_UPDATE: begin
                if (p == LAST_PROC) begin
                    state_n = STAGE_CHECK;
                    p_n     = '0;
                end else begin
                    p_n = p + PID_W'(1);
                end
            end
            // CHECK and the walker's done pulse share the same "next processor" step
            STAGE_CHECK, STAGE_TRANSMIT: begin
                if (state == STAGE_CHECK && (ss == SS_START || ss == SS_STOP)) begin
                    walk_start = 1'b1;
                    state_n    = STAGE_TRANSMIT;
                end else if (state == STAGE_CHECK || walk_done) begin
                    if (p == LAST_PROC) begin
                        state_n = STAGE_WAIT;
                        p_n     = '0;
                    end else begin
                        state_n = STAGE_CHECK;
                        p_n     = p + PID_W'(1);
                    end
                end
            end
            default: state_n = STAGE_WAIT;
        endcase
    end

    always_ff @(posedge clock_fast or posedge reset) begin
        if (reset) begin
            state         <= STAGE_WAIT;
            p             <= '0;
            out_valid     <= 1'b0;
            out_proc      <= '0;
            out_startstop <= SS_NONE;
        end else begin
            state         <= state_n;
            p             <= p_n;
            out_valid     <= check_fire;
            out_proc      <= check_fire ? p : '0;
            out_startstop <= check_fire ? ss : SS_NONE;
        end
    end

    assign stage       = state;
    assign proc_addr   = p;
    assign proc_update = (state == STAGE_UPDATE);
    assign proc_check  = (state == STAGE_CHECK);
    assign busy        = (state != STAGE_WAIT);

    ttt_csr_walker #(
        .NUM_PROCESSORS (NUM_PROCESSORS),
        .NUM_CONNECTIONS(NUM_CONNECTIONS),
        .NEW_TOKEN_BITS (NEW_TOKEN_BITS)
    ) u_walker (
        .clock_fast    (clock_fast),
        .reset         (reset),
        .start         (walk_start),
        .stop_kind     (token_stop),
        .proc          (p),
        .done          (walk_done),
        .indptr_addr   (indptr_addr),
        .indptr_data   (indptr_data),
        .conn_addr     (conn_addr),
        .conn_rd       (conn_rd),
        .conn_target   (conn_target),
        .conn_good     (conn_good),
        .conn_bad      (conn_bad),
        .deliver_valid (deliver_valid),
        .deliver_target(deliver_target),
        .deliver_good  (deliver_good),
        .deliver_bad   (deliver_bad),
        .deliver_stop  (deliver_stop)
    );

endmodule

// File: tb/tb_ttt_stage_scheduler.sv
// Directed self-checking bench for ttt_stage_scheduler with behavioural indptr/connection memories.
module tb_ttt_stage_scheduler;

    logic       clock_fast = 1'b0;
    logic       reset;
    logic       advance;
    logic [1:0] stage;
    logic [2:0] proc_addr;
    logic       proc_update, proc_check;
    logic       token_start, token_stop;
    logic [3:0] indptr_addr;
    logic [5:0] indptr_data;
    logic [4:0] conn_addr;
    logic       conn_rd;
    logic [2:0] conn_target;
    logic [1:0] conn_good, conn_bad;
    logic       deliver_valid;
    logic [2:0] deliver_target;
    logic [1:0] deliver_good, deliver_bad;
    logic       deliver_stop;
    logic       out_valid;
    logic [2:0] out_proc;
    logic [1:0] out_startstop;
    logic       busy;

    logic [5:0] indptr_mem [0:15];
    logic [2:0] tgt_mem    [0:31];
    logic [1:0] good_mem   [0:31];
    logic [1:0] bad_mem    [0:31];
    logic       tok_start  [0:7];
    logic       tok_stop   [0:7];

    int n_checks = 0;
    int n_fail   = 0;

    // per-step logs
    int stage_log [0:511];
    int addr_log  [0:511];
    int upd_log   [0:511];
    int chk_log   [0:511];
    int busy_cycles, tx_cycles, first_tx, p4_check_cyc;
    int out_n, out_cyc, out_pid, out_ss;
    int dv_n;
    int dv_cyc [0:63];
    int dv_tgt [0:63];
    int dv_good[0:63];
    int dv_bad [0:63];
    int dv_stp [0:63];

    always #5 clock_fast = ~clock_fast;

    ttt_stage_scheduler #(
        .NUM_PROCESSORS (8),
        .NUM_CONNECTIONS(32),
        .NEW_TOKEN_BITS (2)
    ) dut (
        .clock_fast    (clock_fast),
        .reset         (reset),
        .advance       (advance),
        .stage         (stage),
        .proc_addr     (proc_addr),
        .proc_update   (proc_update),
        .proc_check    (proc_check),
        .token_start   (token_start),
        .token_stop    (token_stop),
        .indptr_addr   (indptr_addr),
        .indptr_data   (indptr_data),
        .conn_addr     (conn_addr),
        .conn_rd       (conn_rd),
        .conn_target   (conn_target),
        .conn_good     (conn_good),
        .conn_bad      (conn_bad),
        .deliver_valid (deliver_valid),
        .deliver_target(deliver_target),
        .deliver_good  (deliver_good),
        .deliver_bad   (deliver_bad),
        .deliver_stop  (deliver_stop),
        .out_valid     (out_valid),
        .out_proc      (out_proc),
        .out_startstop (out_startstop),
        .busy          (busy)
    );

    assign token_start = tok_start[proc_addr];
    assign token_stop  = tok_stop[proc_addr];

    always @(posedge clock_fast) begin
        indptr_data <= indptr_mem[indptr_addr];
        if (conn_rd) begin
            conn_target <= tgt_mem[conn_addr];
            conn_good   <= good_mem[conn_addr];
            conn_bad    <= bad_mem[conn_addr];
        end
    end

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock_fast);
        #1;
    endtask

    task automatic clear_tokens();
        for (int i = 0; i < 8; i++) begin
            tok_start[i] = 1'b0;
            tok_stop[i]  = 1'b0;
        end
    endtask

    // Pulse advance, then log every cycle until busy drops; adv_again re-pulses advance mid-step.
    task automatic run_step(input int adv_again);
        int cyc;
        out_n = 0; out_cyc = -1; out_pid = -1; out_ss = -1;
        dv_n = 0; tx_cycles = 0; first_tx = -1; p4_check_cyc = -1;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        cyc = 1;
        while (busy && cyc < 400) begin
            stage_log[cyc] = int'(stage);
            addr_log[cyc]  = int'(proc_addr);
            upd_log[cyc]   = int'(proc_update);
            chk_log[cyc]   = int'(proc_check);
            if (stage == 2'b11) begin
                tx_cycles++;
                if (first_tx < 0) first_tx = cyc;
            end
            if (proc_check && proc_addr == 3'd4) p4_check_cyc = cyc;
            if (out_valid) begin
                out_n++;
                out_cyc = cyc; out_pid = int'(out_proc); out_ss = int'(out_startstop);
            end
            if (deliver_valid && dv_n < 64) begin
                dv_cyc[dv_n]  = cyc;
                dv_tgt[dv_n]  = int'(deliver_target);
                dv_good[dv_n] = int'(deliver_good);
                dv_bad[dv_n]  = int'(deliver_bad);
                dv_stp[dv_n]  = int'(deliver_stop);
                dv_n++;
            end
            advance = (cyc == adv_again);
            tick();
            cyc++;
        end
        advance = 1'b0;
        busy_cycles = cyc - 1;
        if (cyc >= 400) check_eq("step_timeout", cyc, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) indptr_mem[i] = '0;
        for (int i = 0; i < 32; i++) begin
            tgt_mem[i]  = 3'(i % 8);
            good_mem[i] = 2'(i % 4);
            bad_mem[i]  = 2'((i / 4) % 4);
        end
        clear_tokens();
        advance = 1'b0;
        reset   = 1'b1;
        tick();
        tick();

        check_eq("rst_stage",         int'(stage), 0);
        check_eq("rst_busy",          int'(busy), 0);
        check_eq("rst_proc_addr",     int'(proc_addr), 0);
        check_eq("rst_strobes",       int'({proc_update, proc_check, conn_rd}), 0);
        check_eq("rst_out",           int'({out_valid, out_proc, out_startstop}), 0);
        check_eq("rst_deliver",       int'({deliver_valid, deliver_stop}), 0);
        check_eq("rst_addrs",         int'({indptr_addr, conn_addr}), 0);
        reset = 1'b0;
        tick();

        // Silent step
        run_step(-1);
        check_eq("silent_busy", busy_cycles, 16);
        for (int c = 1; c <= 8; c++) begin
            check_eq("silent_upd_stage", stage_log[c], 1);
            check_eq("silent_upd_addr",  addr_log[c], c - 1);
            check_eq("silent_upd_strobe", upd_log[c], 1);
        end
        for (int c = 9; c <= 16; c++) begin
            check_eq("silent_chk_stage", stage_log[c], 2);
            check_eq("silent_chk_addr",  addr_log[c], c - 9);
            check_eq("silent_chk_strobe", chk_log[c], 1);
        end
        check_eq("silent_out_n", out_n, 0);
        check_eq("silent_dv_n", dv_n, 0);
        check_eq("silent_end_stage", int'(stage), 0);

        // advance during UPDATE is ignored
        run_step(4);
        check_eq("adv_ignored_busy", busy_cycles, 16);
        check_eq("adv_ignored_end", int'(stage), 0);

        // Processor 3 start-only, targets 1,2,5
        indptr_mem[3] = 6'd4; indptr_mem[4] = 6'd7;
        tgt_mem[4] = 3'd1; tgt_mem[5] = 3'd2; tgt_mem[6] = 3'd5;
        for (int i = 4; i <= 6; i++) begin good_mem[i] = 2'd1; bad_mem[i] = 2'd0; end
        tok_start[3] = 1'b1;
        run_step(-1);
        check_eq("p3_busy", busy_cycles, 23);
        check_eq("p3_out_n", out_n, 1);
        check_eq("p3_out_cyc", out_cyc, 13);
        check_eq("p3_out_proc", out_pid, 3);
        check_eq("p3_out_ss", out_ss, 1);
        check_eq("p3_first_tx", first_tx, 13);
        check_eq("p3_tx_cycles", tx_cycles, 7);
        check_eq("p3_dv_n", dv_n, 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("p3_dv_cyc", dv_cyc[i], 17 + i);
            check_eq("p3_dv_good", dv_good[i], 1);
            check_eq("p3_dv_bad", dv_bad[i], 0);
            check_eq("p3_dv_stop", dv_stp[i], 0);
        end
        check_eq("p3_dv_tgt0", dv_tgt[0], 1);
        check_eq("p3_dv_tgt1", dv_tgt[1], 2);
        check_eq("p3_dv_tgt2", dv_tgt[2], 5);
        check_eq("p3_resume_p4", p4_check_cyc, 20);

        // Processor 7 stop-only, single connection at index 10
        clear_tokens();
        indptr_mem[7] = 6'd10; indptr_mem[8] = 6'd11;
        tgt_mem[10] = 3'd6; good_mem[10] = 2'd2; bad_mem[10] = 2'd3;
        tok_stop[7] = 1'b1;
        run_step(-1);
        check_eq("p7_busy", busy_cycles, 21);
        check_eq("p7_out_cyc", out_cyc, 17);
        check_eq("p7_out_proc", out_pid, 7);
        check_eq("p7_out_ss", out_ss, 2);
        check_eq("p7_dv_n", dv_n, 1);
        check_eq("p7_dv_cyc", dv_cyc[0], 21);
        check_eq("p7_dv_tgt", dv_tgt[0], 6);
        check_eq("p7_dv_good", dv_good[0], 2);
        check_eq("p7_dv_bad", dv_bad[0], 3);
        check_eq("p7_dv_stop", dv_stp[0], 1);
        check_eq("p7_end_stage", int'(stage), 0);

        // Processor 2 start+stop: event only, no walk
        clear_tokens();
        tok_start[2] = 1'b1; tok_stop[2] = 1'b1;
        run_step(-1);
        check_eq("p2_busy", busy_cycles, 16);
        check_eq("p2_out_cyc", out_cyc, 12);
        check_eq("p2_out_proc", out_pid, 2);
        check_eq("p2_out_ss", out_ss, 3);
        check_eq("p2_tx_cycles", tx_cycles, 0);
        check_eq("p2_dv_n", dv_n, 0);

        // Processor 5 with empty list 9..9
        clear_tokens();
        indptr_mem[5] = 6'd9; indptr_mem[6] = 6'd9;
        tok_start[5] = 1'b1;
        run_step(-1);
        check_eq("p5e_busy", busy_cycles, 19);
        check_eq("p5e_out_cyc", out_cyc, 15);
        check_eq("p5e_tx_cycles", tx_cycles, 3);
        check_eq("p5e_dv_n", dv_n, 0);

        // Same with hi=40, clamped to 32: list 9..31
        indptr_mem[6] = 6'd40;
        run_step(-1);
        check_eq("p5c_busy", busy_cycles, 43);
        check_eq("p5c_dv_n", dv_n, 23);
        check_eq("p5c_first_cyc", dv_cyc[0], 19);
        check_eq("p5c_first_tgt", dv_tgt[0], 1);
        check_eq("p5c_first_bad", dv_bad[0], 2);
        check_eq("p5c_last_cyc", dv_cyc[22], 41);
        check_eq("p5c_last_tgt", dv_tgt[22], 7);
        check_eq("p5c_last_good", dv_good[22], 3);
        check_eq("p5c_last_bad", dv_bad[22], 3);

        // Reset asserted mid-WALK of processor 3
        clear_tokens();
        tok_start[3] = 1'b1;
        advance = 1'b1;
        tick();
        advance = 1'b0;
        for (int i = 1; i < 17; i++) tick();
        check_eq("rw_pre_dv", int'(deliver_valid), 1);
        check_eq("rw_pre_stage", int'(stage), 3);
        reset = 1'b1;
        #2;
        check_eq("rw_stage", int'(stage), 0);
        check_eq("rw_dv", int'(deliver_valid), 0);
        check_eq("rw_busy", int'(busy), 0);
        check_eq("rw_conn_rd", int'(conn_rd), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rw_post_dv", int'(deliver_valid), 0);
            check_eq("rw_post_stage", int'(stage), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_stage_scheduler.md
# ttt_stage_scheduler

Sequencer for one simulation step of the tick-tock-tokens processor array. On an `advance` command it sweeps every processor through its update and check phases. For each processor that emits a start-only or stop-only token, it walks that processor's CSR fan-out list (indptr/indices memories) and streams weighted token deliveries to the target processors. It drives the 2-bit `stage` status reported on the chip outputs, plus the fired-processor event.

## Interface
- `NUM_PROCESSORS`, 8, processor count N; `PID_W = $clog2(N)`, `PTR_W = $clog2(N+1)`
- `NUM_CONNECTIONS`, 32, connection memory depth C; `CID_W = $clog2(C)`, `CNT_W = $clog2(C+1)`
- `NEW_TOKEN_BITS`, 2, weight width W

- `clock_fast` in 1: sole clock, all state on rising edge
- `reset` in 1: asynchronous, active-high
- `advance` in 1: decoded "advance" command (op 0010), single-cycle pulse
- `stage` out 2: 00 wait, 01 update, 10 check, 11 transmit
- `proc_addr` out PID_W: processor currently visited
- `proc_update` out 1: update strobe for `proc_addr`
- `proc_check` out 1: check strobe for `proc_addr`
- `token_start`, `token_stop` in 1 each: combinational check result for `proc_addr`, sampled while `proc_check`=1
- `indptr_addr` out PTR_W: indptr read address, synchronous read, 1-cycle latency
- `indptr_data` in CNT_W: indptr read data
- `conn_addr` out CID_W; `conn_rd` out 1: connection memory read, 1-cycle latency
- `conn_target` in PID_W; `conn_good`, `conn_bad` in W: connection read data
- `deliver_valid` out 1; `deliver_target` out PID_W; `deliver_good`, `deliver_bad` out W; `deliver_stop` out 1 (1 = subtract weights)
- `out_valid` out 1; `out_proc` out PID_W; `out_startstop` out 2: fired-processor event
- `busy` out 1: high in every state except WAIT

## Operation
- Fan-out list of processor p is `[indptr[p], indptr[p+1])`. indptr has N+1 entries. Values greater than C are clamped to C.
- WAIT (stage 00): `advance` moves to UPDATE with p=0. `advance` in any other state is ignored.
- UPDATE (01): `proc_update`=1 with `proc_addr`=p, one cycle per processor. After p=N-1, go to CHECK with p=0.
- CHECK (10): `proc_check`=1 with `proc_addr`=p; sample start/stop.
  - Nonzero result: register `out_valid`/`out_proc`=p/`out_startstop`={stop,start}, visible next cycle for one cycle.
  - start XOR stop: latch `deliver_stop`=stop, go to PTR0.
  - Both set (net zero) or neither: no walk. If p=N-1 go to WAIT, else p+1.
- PTR0 (11): `indptr_addr`=p.
- PTR1 (11): `indptr_addr`=p+1; capture lo.
- PTR2 (11): capture hi. If lo≥hi (empty or mis-programmed list), continue as after CHECK. Otherwise go to WALK with c=lo.
- WALK (11): `conn_rd`=1, `conn_addr`=c, then c+1. When c=hi-1, go to DRAIN.
- DRAIN (11): last delivery emitted, then continue as after CHECK.
- Delivery: `deliver_valid` = `conn_rd` delayed 1 cycle. `deliver_target`/`deliver_good`/`deliver_bad` pass through combinationally from connection memory data. `deliver_stop` holds the latched kind.

## Timing
- Reset values: state WAIT, `stage`=00, p=0, all strobes/valids 0, all addresses 0, `out_*` 0, `deliver_stop`=0.
- Reset mid-operation aborts immediately. No partial delivery is emitted after reset deassertion.
- `advance` at cycle 0 gives `stage`=01 from cycle 1 for N cycles, then `stage`=10.
- Non-firing processor in CHECK: 1 cycle.
- Firing processor with k>0 connections: k+5 cycles (check, 3 pointer, k walk, drain). Empty list: 4 cycles.
- Silent step: `busy` high for exactly 2N cycles.
- Deliveries are back-to-back, one per cycle, in ascending connection index.
- `out_valid` precedes the processor's first `deliver_valid` by 4 cycles.
- p wraps only through WAIT. There is no back-pressure; consumers accept one delivery per cycle.

## Structure
- Shared package `ttt_pkg`:
  - `stage_t` enum (`STAGE_WAIT`, `STAGE_UPDATE`, `STAGE_CHECK`, `STAGE_TRANSMIT` = 00..11)
  - start/stop code constants
  - width helper functions for PID/PTR/CID/CNT
- Sub-module `ttt_csr_walker`: PTR0..DRAIN states, lo/hi/c registers, clamping, and delivery pipeline. Started by a `start` pulse with p; returns a `done` pulse.

## Test plan
- Reset, no tokens, `advance`: `stage` 00→01 (cycles 1-8, `proc_addr` 0..7)→10 (cycles 9-16)→00. No `out_valid`, `busy` high 16 cycles.
- Processor 3 start-only, indptr[3]=4, indptr[4]=7, conn 4..6 = targets 1,2,5, good=1, bad=0 → `out_valid` with `out_startstop`=01, `out_proc`=3, then 3 consecutive `deliver_valid` to 1,2,5 with `deliver_stop`=0, then check resumes at p=4.
- Processor 7 stop-only, single connection → one delivery with `deliver_stop`=1, then return to WAIT.
- Processor 2 start+stop → `out_startstop`=11, no PTR/WALK states, no delivery.
- indptr[5]=9, indptr[6]=9 → 4-cycle empty walk, no delivery. Repeat with indptr[6]=40 → hi clamped to 32.
- `reset` asserted mid-WALK → `stage`=00, `deliver_valid`=0 immediately. `advance` during UPDATE is ignored.
